// File: rtl/result_bcd_display.sv
// Result display back end: converts the 11-bit two's-complement result to sign + 4 BCD digits
// by sequential double-dabble and scans them onto a 5-position multiplexed 7-segment display.
module result_bcd_display #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] data_in,
    output logic        busy,
    output logic        neg,
    output logic [15:0] bcd,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    state_t      state_q;
    logic [10:0] d_q;
    logic [10:0] last_q;
    logic        sign_q;
    logic [10:0] mag_q;
    logic [15:0] bcd_w_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        neg_q;
    logic [15:0] bcd_q;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       pos_q;
    logic [4:0]       an_q;
    logic [6:0]       seg_q;

    logic [10:0] mag_d;
    logic [15:0] bcd_adj_d;
    logic [3:0]  lead_blank;
    logic [3:0]  digit_d;
    logic [6:0]  seg_d;

    function automatic logic [6:0] encode_digit(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Magnitude of the sampled word; -1024 maps to 1024, which still fits 11 unsigned bits.
    assign mag_d = d_q[10] ? (~d_q + 11'd1) : d_q;

    always_comb begin
        bcd_adj_d = bcd_w_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_w_q[4*k +: 4] >= 4'd5) begin
                bcd_adj_d[4*k +: 4] = bcd_w_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            last_q  <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_w_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            d_q <= data_in;
            case (state_q)
                ST_IDLE: begin
                    if (d_q != last_q) begin
                        last_q  <= d_q;
                        sign_q  <= d_q[10];
                        mag_q   <= mag_d;
                        bcd_w_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_w_q <= {bcd_adj_d[14:0], mag_q[10]};
                    mag_q   <= {mag_q[9:0], 1'b0};
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd10) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd_q   <= bcd_w_q;
                    neg_q   <= sign_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A digit is a leading zero when it and every higher digit are zero; units never blank.
    assign lead_blank[3] = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
    assign lead_blank[2] = lead_blank[3] && (bcd_q[11:8] == 4'd0);
    assign lead_blank[1] = lead_blank[2] && (bcd_q[7:4] == 4'd0);
    assign lead_blank[0] = 1'b0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        digit_d = 4'd0;
        seg_d   = SEG_BLANK;
        case (pos_q)
            3'd0: digit_d = bcd_q[3:0];
            3'd1: digit_d = bcd_q[7:4];
            3'd2: digit_d = bcd_q[11:8];
            3'd3: digit_d = bcd_q[15:12];
            default: digit_d = 4'd0;
        endcase
        if (pos_q == 3'd4) begin
            seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
        end else if (pos_q < 3'd4) begin
            seg_d = lead_blank[pos_q[1:0]] ? SEG_BLANK : encode_digit(digit_d);
        end
    end

    // an and seg are registered on the same edge so position and pattern never skew.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            pos_q <= '0;
            an_q  <= 5'h1F;
            seg_q <= SEG_BLANK;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                pos_q <= (pos_q == 3'd4) ? 3'd0 : pos_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            an_q  <= ~(5'b00001 << pos_q);
            seg_q <= seg_d;
        end
    end

    assign busy = busy_q;
    assign neg  = neg_q;
    assign bcd  = bcd_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display: table vectors, corner sequences and random values
// compared against an arithmetic reference model of the displayed value.
module tb_result_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] data_in = '0;
    logic        busy, neg, busy_nb, neg_nb;
    logic [15:0] bcd, bcd_nb;
    logic [4:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;

    int n_tests = 0;
    int n_fail  = 0;
    int shown   = 0;

    logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    result_bcd_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .busy(busy), .neg(neg),
        .bcd(bcd), .an(an), .seg(seg)
    );

    result_bcd_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .data_in(data_in), .busy(busy_nb), .neg(neg_nb),
        .bcd(bcd_nb), .an(an_nb), .seg(seg_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          value;
        logic [15:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int abs_val(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        int m;
        m = abs_val(v);
        return {4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int pos, input bit blank_lead);
        int m, p10;
        m = abs_val(v);
        if (pos == 4) return (v < 0) ? 7'b0111111 : 7'b1111111;
        p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
        if (blank_lead && pos > 0 && m < p10) return 7'b1111111;
        return seg_lut[(m / p10) % 10];
    endfunction

    function automatic int an_pos(input logic [4:0] a);
        case (a)
            5'b11110: return 0;
            5'b11101: return 1;
            5'b11011: return 2;
            5'b10111: return 3;
            5'b01111: return 4;
            default:  return -1;
        endcase
    endfunction

    // Input was driven at a negedge; watch 16 negedges: busy on 2..13, new value from 14.
    task automatic observe(input int old_v, input int new_v, input bit conv, input string name);
        int bad_busy = 0, bad_hold = 0;
        logic exp_busy;
        logic [15:0] exp_b;
        logic exp_n;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_busy = conv && i >= 2 && i <= 13;
            exp_b = (conv && i >= 14) ? model_bcd(new_v) : model_bcd(old_v);
            exp_n = (conv && i >= 14) ? (new_v < 0) : (old_v < 0);
            if (busy !== exp_busy) bad_busy++;
            if (bcd !== exp_b || neg !== exp_n) bad_hold++;
        end
        check({name, " busy_timing"}, bad_busy, 0);
        check({name, " bcd_timeline"}, bad_hold, 0);
        check({name, " bcd"}, bcd, model_bcd(new_v));
        check({name, " neg"}, neg, (new_v < 0));
        shown = new_v;
    endtask

    task automatic convert(input int v, input string name);
        @(negedge clk);
        data_in = 11'(v);
        observe(shown, v, v != shown, name);
    endtask

    task automatic scan_check(input int v, input bit nb, input string name);
        int prev = -1, run = 0, trans = 0, bad_an = 0, bad_seg = 0, bad_seq = 0, p;
        logic [4:0] a;
        logic [6:0] s;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            a = nb ? an_nb : an;
            s = nb ? seg_nb : seg;
            p = an_pos(a);
            if (p < 0) begin
                bad_an++;
            end else begin
                if (s !== model_seg(v, p, !nb)) bad_seg++;
                if (p == prev) begin
                    run++;
                end else begin
                    if (prev >= 0) begin
                        if (p != (prev + 1) % 5) bad_seq++;
                        if (trans > 0 && run != 4) bad_seq++;
                        trans++;
                    end
                    prev = p;
                    run = 1;
                end
            end
        end
        check({name, " an_onehot"}, bad_an, 0);
        check({name, " seg"}, bad_seg, 0);
        check({name, " scan_order"}, bad_seq, 0);
        check({name, " scan_moves"}, (trans >= 9), 1);
    endtask

    initial begin
        vec_t vecs [12];
        int bad_an, bad_seg, bad_busy, bad_b, v, raw;
        logic exp_busy;
        logic [15:0] exp_b;

        vecs[0]  = '{123,   16'h0123, 1'b0};
        vecs[1]  = '{-1,    16'h0001, 1'b1};
        vecs[2]  = '{-1024, 16'h1024, 1'b1};
        vecs[3]  = '{1023,  16'h1023, 1'b0};
        vecs[4]  = '{-999,  16'h0999, 1'b1};
        vecs[5]  = '{10,    16'h0010, 1'b0};
        vecs[6]  = '{100,   16'h0100, 1'b0};
        vecs[7]  = '{1000,  16'h1000, 1'b0};
        vecs[8]  = '{1000,  16'h1000, 1'b0};
        vecs[9]  = '{-5,    16'h0005, 1'b1};
        vecs[10] = '{0,     16'h0000, 1'b0};
        vecs[11] = '{560,   16'h0560, 1'b0};

        // Reset state, then idle display of 0 with no conversion.
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset neg", neg, 0);
        check("reset bcd", bcd, 16'h0000);
        check("reset an", an, 5'h1F);
        check("reset seg", seg, 7'h7F);
        rst = 1'b1;
        bad_an = 0; bad_seg = 0; bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== ~(5'b00001 << (i / 4))) bad_an++;
            if (seg !== model_seg(0, i / 4, 1'b1)) bad_seg++;
            if (busy !== 1'b0 || bcd !== 16'h0000) bad_busy++;
        end
        check("post_reset an_sequence", bad_an, 0);
        check("post_reset seg", bad_seg, 0);
        check("post_reset idle", bad_busy, 0);

        // Table vectors with constant expectations, plus scan checks on a few.
        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].value, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table_bcd", i), bcd, vecs[i].exp_bcd);
            check($sformatf("vec%0d table_neg", i), neg, vecs[i].exp_neg);
            if (i == 0 || i == 1 || i == 10) scan_check(vecs[i].value, 1'b0, $sformatf("vec%0d scan", i));
        end

        // Change during conversion: 5, then 7 on the 5th busy cycle.
        @(negedge clk);
        data_in = 11'd5;
        bad_busy = 0; bad_b = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 6) data_in = 11'd7;
            exp_busy = (i >= 2 && i <= 13) || (i >= 15 && i <= 26);
            exp_b = (i >= 27) ? 16'h0007 : (i >= 14) ? 16'h0005 : model_bcd(shown);
            if (busy !== exp_busy) bad_busy++;
            if (bcd !== exp_b) bad_b++;
        end
        check("restart busy_timing", bad_busy, 0);
        check("restart bcd_timeline", bad_b, 0);
        check("restart final_bcd", bcd, 16'h0007);
        shown = 7;

        // BLANK_LEADING=0 instance shows all digits of 7.
        scan_check(7, 1'b1, "noblank 7");

        // Reset in the middle of a conversion of 999.
        @(negedge clk);
        data_in = 11'd999;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midconv_reset busy", busy, 0);
        check("midconv_reset bcd", bcd, 16'h0000);
        check("midconv_reset an", an, 5'h1F);
        check("midconv_reset seg", seg, 7'h7F);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        observe(0, 999, 1'b1, "post_reset 999");

        // Random values against the model; occasional repeats exercise the no-change path.
        for (int i = 0; i < 25; i++) begin
            raw = int'($urandom_range(0, 2047));
            v = (raw >= 1024) ? raw - 2048 : raw;
            if (i % 7 == 3) v = shown;
            convert(v, $sformatf("rand%0d", i));
            if (i % 6 == 0) scan_check(v, 1'b0, $sformatf("rand%0d scan", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
